// File: rtl/rdi_sb_pkg.sv
// Shared RDI sideband definitions: default widths, arbiter state encoding, watchdog default.
package rdi_sb_pkg;

  localparam int unsigned MSG_W_DEF          = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;
  localparam int unsigned GAP_W              = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rdi_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr+1 (mod NUM_REQ).
module rdi_rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  // Scan candidates ptr+1 .. ptr+NUM_REQ, keep the first hit.
  always_comb begin
    int unsigned cand;
    logic        found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(ptr) + i) % NUM_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        found                = 1'b1;
        gnt[IDX_W'(cand)]    = 1'b1;
        idx                  = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/rdi_sb_msg_arbiter.sv
// Round-robin arbiter for the RDI sideband TX message channel.
// Grant held until sideband done, followed by GAP_CYCLES idle cycles.
// Optional SEND watchdog enabled by defining RDI_SB_ARB_TIMEOUT_EN.
module rdi_sb_msg_arbiter
  import rdi_sb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned MSG_W          = MSG_W_DEF,
  parameter int unsigned GAP_CYCLES     = 1,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                     lclk,
  input  logic                     sys_rst,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*MSG_W-1:0] i_msg,
  input  logic                     i_sb_done_send,
  output logic [MSG_W-1:0]         o_tx_sb_message,
  output logic                     o_tx_msg_valid,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_done_pulse,
  output logic                     o_busy,
  output logic                     o_timeout
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("rdi_sb_msg_arbiter: NUM_REQ must be 2..8");
  end
  if (GAP_CYCLES > 15) begin : g_bad_gap
    $error("rdi_sb_msg_arbiter: GAP_CYCLES must be 0..15");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("rdi_sb_msg_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  arb_state_e          state, state_d;
  logic [IDX_W-1:0]    ptr, ptr_d;
  logic [IDX_W-1:0]    owner, owner_d;
  logic [GAP_W-1:0]    gap_cnt, gap_cnt_d;
  logic                first, first_d;
  logic [MSG_W-1:0]    msg_d;
  logic                valid_d;
  logic [NUM_REQ-1:0]  grant_d;
  logic [NUM_REQ-1:0]  done_pulse_d;
  logic                busy_d;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]    pick_idx;
  arb_state_e          after_send;

`ifdef RDI_SB_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt, to_cnt_d;
  logic            timeout_d;
`else
  assign o_timeout = 1'b0;
`endif

  assign after_send = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  rdi_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (i_req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    ptr_d        = ptr;
    owner_d      = owner;
    gap_cnt_d    = gap_cnt;
    first_d      = 1'b0;
    msg_d        = o_tx_sb_message;
    valid_d      = o_tx_msg_valid;
    grant_d      = o_grant;
    done_pulse_d = '0;
`ifdef RDI_SB_ARB_TIMEOUT_EN
    to_cnt_d     = to_cnt;
    timeout_d    = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (|i_req) begin
          msg_d   = i_msg[32'(pick_idx)*MSG_W +: MSG_W];
          grant_d = pick_gnt;
          owner_d = pick_idx;
          valid_d = 1'b1;
          first_d = 1'b1;
          state_d = ST_SEND;
`ifdef RDI_SB_ARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      ST_SEND: begin
`ifdef RDI_SB_ARB_TIMEOUT_EN
        to_cnt_d = to_cnt + TO_W'(1);
`endif
        if (i_sb_done_send && !first) begin
          valid_d      = 1'b0;
          grant_d      = '0;
          done_pulse_d = o_grant;
          ptr_d        = owner;
          gap_cnt_d    = '0;
          state_d      = after_send;
        end
`ifdef RDI_SB_ARB_TIMEOUT_EN
        else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          valid_d   = 1'b0;
          grant_d   = '0;
          timeout_d = 1'b1;
          ptr_d     = owner;
          gap_cnt_d = '0;
          state_d   = after_send;
        end
`endif
      end
      ST_GAP: begin
        if ((5'(gap_cnt) + 5'd1) >= 5'(GAP_CYCLES)) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge lclk) begin
    if (sys_rst) begin
      state           <= ST_IDLE;
      ptr             <= IDX_W'(NUM_REQ - 1);
      owner           <= '0;
      gap_cnt         <= '0;
      first           <= 1'b0;
      o_tx_sb_message <= '0;
      o_tx_msg_valid  <= 1'b0;
      o_grant         <= '0;
      o_done_pulse    <= '0;
      o_busy          <= 1'b0;
`ifdef RDI_SB_ARB_TIMEOUT_EN
      to_cnt          <= '0;
      o_timeout       <= 1'b0;
`endif
    end else begin
      state           <= state_d;
      ptr             <= ptr_d;
      owner           <= owner_d;
      gap_cnt         <= gap_cnt_d;
      first           <= first_d;
      o_tx_sb_message <= msg_d;
      o_tx_msg_valid  <= valid_d;
      o_grant         <= grant_d;
      o_done_pulse    <= done_pulse_d;
      o_busy          <= busy_d;
`ifdef RDI_SB_ARB_TIMEOUT_EN
      to_cnt          <= to_cnt_d;
      o_timeout       <= timeout_d;
`endif
    end
  end

endmodule
